// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the host command framer: state encodings, error
// causes and default framing constants.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_AHI  = 3'd2,
    S_ALO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CLKS_PER_BIT  = 5208;

endpackage

// File: rtl/uart_cmd_parser_gap_timer.sv
// Inter-byte gap timer. Counts up while enabled and pulses expired for one
// cycle when it sits on TERMINAL-1 with no clear that cycle. The pulse also
// clears the count, so the counter never wraps.
module byte_gap_timer #(
  parameter int TERMINAL = 104160
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             W  = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [W-1:0]   TC = W'(TERMINAL - 1);

  logic [W-1:0] cnt;

  // A clear in the same cycle as terminal count wins: no expiry.
  assign expired = en && !clr && (cnt == TC);

  // Gap counter: cleared by a byte, by idle, or by its own expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the receiver byte stream into range-sensor host commands:
// SYNC, CMD, ARG_HI, ARG_LO, CHK with CHK = CMD ^ ARG_HI ^ ARG_LO.
//
// state  | meaning
// S_IDLE | waiting for SYNC_BYTE, other bytes dropped silently
// S_CMD  | expecting command byte
// S_AHI  | expecting argument high byte
// S_ALO  | expecting argument low byte
// S_CHK  | expecting checksum byte
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = 104160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic        busy
);

  state_t     state, state_nxt;
  logic [7:0] sh_cmd, sh_hi, sh_lo, xor_acc;
  logic       load_cmd, flag_chk, flag_tmo;
  logic       expired;

  assign busy = (state != S_IDLE);

  // Timer is held clear in idle so every frame starts with a fresh gap.
  byte_gap_timer #(.TERMINAL(TIMEOUT_CLKS)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rx_done || !busy),
    .en      (busy),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and one-cycle event decode; expiry implies no byte this cycle.
  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    flag_chk  = 1'b0;
    flag_tmo  = 1'b0;
    case (state)
      S_IDLE: if (rx_done && rx_data == SYNC_BYTE) state_nxt = S_CMD;
      S_CMD:  if (rx_done) state_nxt = S_AHI;
      S_AHI:  if (rx_done) state_nxt = S_ALO;
      S_ALO:  if (rx_done) state_nxt = S_CHK;
      S_CHK: begin
        if (rx_done) begin
          state_nxt = S_IDLE;
          if (rx_data == xor_acc) load_cmd = 1'b1;
          else                    flag_chk = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (expired) begin
      state_nxt = S_IDLE;
      flag_tmo  = 1'b1;
    end
  end

  // Shadow capture, running XOR and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_cmd    <= '0;
      sh_hi     <= '0;
      sh_lo     <= '0;
      xor_acc   <= '0;
      cmd_valid <= 1'b0;
      err_pulse <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
      err_code  <= ERR_NONE;
    end else begin
      cmd_valid <= load_cmd;
      err_pulse <= flag_chk || flag_tmo;
      if (rx_done) begin
        case (state)
          S_CMD: begin sh_cmd <= rx_data; xor_acc <= rx_data;           end
          S_AHI: begin sh_hi  <= rx_data; xor_acc <= xor_acc ^ rx_data; end
          S_ALO: begin sh_lo  <= rx_data; xor_acc <= xor_acc ^ rx_data; end
          default: ;
        endcase
      end
      if (load_cmd) begin
        cmd_code <= sh_cmd;
        cmd_arg  <= {sh_hi, sh_lo};
        err_code <= ERR_NONE;
      end
      if (flag_chk) err_code <= ERR_CHK;
      if (flag_tmo) err_code <= ERR_TMO;
    end
  end

endmodule
